// File: rtl/spi_reg_pkg.sv
// Shared register-map constants and status bit positions for the SPI register bank.
package spi_reg_pkg;

    localparam logic [4:0] IOC_VERSION    = 5'h01;
    localparam logic [4:0] IOC_SCRATCH    = 5'h02;
    localparam logic [4:0] IOC_CTRL       = 5'h03;
    localparam logic [4:0] IOC_STATUS     = 5'h04;
    localparam logic [4:0] IOC_CNT_LO     = 5'h05;
    localparam logic [4:0] IOC_CNT_HI     = 5'h06;
    localparam logic [4:0] IOC_FIFO_DATA  = 5'h07;
    localparam logic [4:0] IOC_FIFO_LEVEL = 5'h08;

    localparam int unsigned ST_OVF    = 0;
    localparam int unsigned ST_UDF    = 1;
    localparam int unsigned ST_WRAP   = 2;
    localparam int unsigned ST_BADIOC = 3;
    localparam int unsigned ST_EMPTY  = 4;
    localparam int unsigned ST_FULL   = 5;

endpackage

// File: rtl/spi_reg_fifo.sv
// First-word-fall-through capture FIFO; reports dropped pushes and empty pops.
module spi_reg_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [4:0] level_o,
    output logic       ovf_o,
    output logic       udf_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [4:0]    level_q, level_d;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == 5'(DEPTH));
    assign empty_o = (level_q == 5'd0);
    assign level_o = level_q;
    assign data_o  = mem_q[rptr_q];

    // A pop on empty is refused first, so a same-cycle push still lands.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign ovf_o   = push_i & full_o;
    assign udf_o   = pop_i & empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Per-chip-select register bank behind the SPI command interface: scratch, control,
// sticky status, event counter with snapshot, and a capture FIFO.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter logic [7:0]  VERSION    = 8'h01,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  CTRL_RESET = 8'h00
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_cs,
    input  logic [4:0] i_ioc,
    input  logic       i_fetch_cmd,
    input  logic       i_load_cmd,
    input  logic [7:0] i_data_in,
    output logic [7:0] o_data_out,
    input  logic       i_event,
    input  logic       i_fifo_wr,
    input  logic [7:0] i_fifo_data,
    output logic [7:0] o_ctrl,
    output logic [4:0] o_fifo_level,
    output logic       o_irq
);

    logic [7:0]  data_q, data_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [3:0]  sticky_q, sticky_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        irq_q;

    logic        rd, wr, both;
    logic [7:0]  rdata;
    logic [7:0]  status_rd;
    logic [3:0]  w1c, set;
    logic        bad, pop, cnt_clr, cnt_wrap;
    logic [7:0]  fifo_head;
    logic        fifo_full, fifo_empty, fifo_ovf, fifo_udf;
    logic [4:0]  fifo_level;

    // A load paired with a fetch wins; the fetch is dropped and flagged.
    assign rd   = i_cs & i_fetch_cmd & ~i_load_cmd;
    assign wr   = i_cs & i_load_cmd;
    assign both = i_cs & i_fetch_cmd & i_load_cmd;

    spi_reg_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (i_sys_clk),
        .rst_i  (i_rst),
        .push_i (i_fifo_wr),
        .pop_i  (pop),
        .data_i (i_fifo_data),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(fifo_level),
        .ovf_o  (fifo_ovf),
        .udf_o  (fifo_udf)
    );

    always_comb begin
        status_rd            = '0;
        status_rd[3:0]       = sticky_q;
        status_rd[ST_EMPTY]  = fifo_empty;
        status_rd[ST_FULL]   = fifo_full;
    end

    always_comb begin
        rdata     = 8'h00;
        bad       = both;
        pop       = 1'b0;
        shadow_d  = shadow_q;
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        w1c       = '0;
        cnt_clr   = 1'b0;

        if (rd) begin
            case (i_ioc)
                IOC_VERSION:    rdata = VERSION;
                IOC_SCRATCH:    rdata = scratch_q;
                IOC_CTRL:       rdata = ctrl_q;
                IOC_STATUS:     rdata = status_rd;
                IOC_CNT_LO: begin
                    rdata    = cnt_q[7:0];
                    shadow_d = cnt_q[15:8];
                end
                IOC_CNT_HI:     rdata = shadow_q;
                IOC_FIFO_DATA: begin
                    pop   = 1'b1;
                    rdata = fifo_empty ? 8'h00 : fifo_head;
                end
                IOC_FIFO_LEVEL: rdata = {3'b000, fifo_level};
                default:        bad = 1'b1;
            endcase
        end

        if (wr) begin
            case (i_ioc)
                IOC_SCRATCH: scratch_d = i_data_in;
                IOC_CTRL:    ctrl_d    = i_data_in;
                IOC_STATUS:  w1c       = i_data_in[3:0];
                IOC_CNT_LO:  cnt_clr   = 1'b1;
                default:     bad       = 1'b1;
            endcase
        end

        cnt_wrap = i_event & (cnt_q == 16'hFFFF) & ~cnt_clr;
        cnt_d    = cnt_clr ? 16'h0000 : cnt_q + {15'b0, i_event};

        set            = '0;
        set[ST_OVF]    = fifo_ovf;
        set[ST_UDF]    = fifo_udf;
        set[ST_WRAP]   = cnt_wrap;
        set[ST_BADIOC] = bad;
        sticky_d       = (sticky_q & ~w1c) | set;

        data_d = rd ? rdata : data_q;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            data_q    <= '0;
            scratch_q <= '0;
            ctrl_q    <= CTRL_RESET;
            sticky_q  <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            irq_q     <= |sticky_q;
        end
    end

    assign o_data_out   = data_q;
    assign o_ctrl       = ctrl_q;
    assign o_fifo_level = fifo_level;
    assign o_irq        = irq_q;

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Register bank that consumes the register-access commands decoded by the SPI command interface: a 5-bit register index (ioc), the per-target chip-select line, fetch/load strobes and the write byte. It returns read data in time for the interface to shift it out. It holds scratch, control, a sticky status register, a 16-bit event counter with a snapshot, and a small capture FIFO that firmware drains over SPI. One instance is used per chip-select target.

Parameters:
VERSION, 8'h01, value returned by the version register
FIFO_DEPTH, 8, capture FIFO depth; power of 2, range 2..16
CTRL_RESET, 8'h00, reset value of the control register

Ports:
i_sys_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_cs  in  1  this bank's bit of the interface's one-hot chip select; stays asserted between transactions
i_ioc  in  5  register index; stable while a fetch or load strobe is high
i_fetch_cmd  in  1  one-cycle read strobe
i_load_cmd  in  1  one-cycle write strobe; i_data_in is valid in the same cycle
i_data_in  in  8  write byte
o_data_out  out  8  read byte
i_event  in  1  event pulse; counts one per cycle high
i_fifo_wr  in  1  capture FIFO push
i_fifo_data  in  8  capture FIFO push data
o_ctrl  out  8  control register contents
o_fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH
o_irq  out  1  OR of the sticky status bits [3:0]

Behaviour:
- Clock and reset: single clock i_sys_clk; reset i_rst is synchronous and active-high.
- Register values after reset:
  - o_data_out = 0, o_ctrl = CTRL_RESET, scratch = 0.
  - Sticky status = 0, counter = 0, shadow = 0.
  - FIFO empty, o_fifo_level = 0, o_irq = 0.
- Access qualification: an access happens only when i_cs=1 together with fetch or load. A strobe with i_cs=0 is ignored entirely.
- Read latency:
  - Fetch in cycle N registers the result into o_data_out at edge N+1.
  - o_data_out holds that value until the next qualified fetch. The interface samples it two cycles after the strobe.
- Write latency: load in cycle N updates the target at edge N+1.
- Register map (ioc):
  - 0x01 VERSION: read-only, returns VERSION.
  - 0x02 SCRATCH: read/write.
  - 0x03 CTRL: read/write, drives o_ctrl.
  - 0x04 STATUS: read returns {2'b0, full, empty, bad_ioc, wrap, underflow, overflow}. Bits [5:4] are live FIFO flags. Bits [3:0] are sticky and write-1-to-clear.
  - 0x05 CNT_LO: read returns cnt[7:0] and copies cnt[15:8] into the shadow in the same edge. Any write clears cnt to 0.
  - 0x06 CNT_HI: read returns the shadow, not the live cnt[15:8]. Writes are ignored.
  - 0x07 FIFO_DATA: read pops the head entry. Writes are ignored.
  - 0x08 FIFO_LEVEL: read returns {3'b0, level}.
  - Any other ioc: read returns 8'h00; a read or write sets bad_ioc. Writes to read-only registers also set bad_ioc.
- Counter:
  - 16-bit and wraps at 0xFFFF→0x0000. A wrap sets the sticky wrap bit.
  - i_event in the same cycle as a CNT_LO write: the clear wins and the event is lost.
- FIFO:
  - Push when full: data dropped, overflow bit set, level unchanged.
  - Pop when empty: returns 8'h00, underflow bit set.
  - Push and pop in the same cycle with 0<level<DEPTH: both take effect, level unchanged.
  - Push and pop in the same cycle with level=0: treated as an underflow pop; the push is then accepted and level becomes 1.
  - Read pointer and write pointer wrap modulo FIFO_DEPTH.
- Sticky status:
  - Set and W1C clear of the same bit in the same cycle: set wins.
  - o_irq is registered, one cycle after a sticky bit changes.
- Reset mid-operation: restores all reset values and discards any pending fetch or load; o_data_out returns to 0.
- Simultaneous fetch and load: not produced by the interface. If both occur, the load is performed, the fetch is ignored, and bad_ioc is set.

Decomposition:
- Shared package spi_reg_pkg holds:
  - IOC_VERSION..IOC_FIFO_LEVEL constants;
  - STATUS bit indices (ST_OVF=0, ST_UDF=1, ST_WRAP=2, ST_BADIOC=3, ST_EMPTY=4, ST_FULL=5).
- One sub-module, spi_reg_fifo: a synchronous FIFO with push/pop/full/empty/level. Its output is first-word-fall-through, so a pop's data is registered into o_data_out at edge N+1.

Test Plan:
1. Reset, then fetch ioc 0x01 (i_cs=1) → o_data_out=0x01 one edge after the strobe; all other outputs at reset values.
2. Load 0x03 with 0xA5, then fetch 0x03 → o_ctrl=0xA5 one edge after the load; read returns 0xA5. Repeat the load with i_cs=0 using 0x5A → o_ctrl stays 0xA5.
3. Apply 0x1234 event pulses; read CNT_LO → 0x34; pulse 0x100 more events; read CNT_HI → 0x12 (shadow). Write CNT_LO in the same cycle as an event → count=0.
4. Push 9 bytes 0x10..0x18 with FIFO_DEPTH=8 → level=8, overflow=1, o_irq=1. Pop 8 times → 0x10..0x17. A 9th pop → 0x00 with underflow=1. Write STATUS 0x03 → bits clear, o_irq=0 next edge.
5. Simultaneous push and pop at level 3 → level remains 3 and data order is preserved. Counter at 0xFFFF plus one event → cnt=0, wrap=1.
6. Fetch ioc 0x1F → 0x00 and bad_ioc=1. Assert i_rst between fetch and sample → o_data_out=0 and sticky bits=0.
